// File: rtl/p2_link_pkg.sv
// Shared definitions for the player-2 button link: button count, bit order
// and the default debounce length.
package p2_link_pkg;

  localparam int NBTN       = 5;
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_ATTACK = 4;

  localparam int DEBOUNCE_CYCLES = 1_000_000;

  typedef logic [NBTN-1:0] btn_vec_t;

  // Bits needed to hold a count from 0 up to n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button line: synchroniser, persistence debouncer, press/release pulses
// and, when P2_AUTOREPEAT_EN is defined, press auto-repeat.
module btn_debounce
  import p2_link_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = p2_link_pkg::DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_pin,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync_p0;
  logic [CW-1:0]          r_cnt_p1;
  logic                   r_stable_p1;
  logic                   r_press_p1;
  logic                   r_release_p1;

  logic w_s;
  logic w_accept;
  logic w_rep_fire;

  assign w_s      = r_sync_p0[SYNC_STAGES-1];
  assign w_accept = (w_s != r_stable_p1) && (r_cnt_p1 == CNT_LAST);

  // Stage p0: synchroniser chain; cleared while disabled so a line already
  // held high when the receiver is enabled still pays the full latency.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_sync_p0 <= '0;
    end else begin
      r_sync_p0 <= {r_sync_p0[SYNC_STAGES-2:0], i_pin};
    end
  end

  // Stage p1: persistence counter, accepted level and edge pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_cnt_p1     <= '0;
      r_stable_p1  <= 1'b0;
      r_press_p1   <= 1'b0;
      r_release_p1 <= 1'b0;
    end else begin
      if (w_s == r_stable_p1) begin
        r_cnt_p1 <= '0;
      end else if (r_cnt_p1 == CNT_LAST) begin
        r_cnt_p1    <= '0;
        r_stable_p1 <= w_s;
      end else begin
        r_cnt_p1 <= r_cnt_p1 + 1'b1;
      end
      r_press_p1   <= (w_accept && w_s) || w_rep_fire;
      r_release_p1 <= w_accept && !w_s;
    end
  end

`ifdef P2_AUTOREPEAT_EN
  localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] REP_FIRST_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT_LAST  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] r_rep_cnt_p1;
  logic          r_rep_first_p1;

  // A release accepted this cycle suppresses any repeat that would coincide.
  assign w_rep_fire = r_stable_p1 && !w_accept &&
                      (r_rep_first_p1 ? (r_rep_cnt_p1 == REP_FIRST_LAST)
                                      : (r_rep_cnt_p1 == REP_NEXT_LAST));

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en || !r_stable_p1 || (w_accept && w_s)) begin
      r_rep_cnt_p1   <= '0;
      r_rep_first_p1 <= 1'b1;
    end else if (w_rep_fire) begin
      r_rep_cnt_p1   <= '0;
      r_rep_first_p1 <= 1'b0;
    end else begin
      r_rep_cnt_p1 <= r_rep_cnt_p1 + 1'b1;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  assign o_level   = r_stable_p1;
  assign o_press   = r_press_p1;
  assign o_release = r_release_p1;

endmodule

// File: rtl/p2_button_link_rx.sv
// Master-board receiver for the five player-2 button lines from the slave
// board. Optional auto-repeat of presses is built when P2_AUTOREPEAT_EN is defined.
module p2_button_link_rx
  import p2_link_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = p2_link_pkg::DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            isMaster,
  input  logic [NBTN-1:0] ja_in,
  output logic [NBTN-1:0] p2_level,
  output logic [NBTN-1:0] p2_press,
  output logic [NBTN-1:0] p2_release
);

  btn_vec_t w_level;
  btn_vec_t w_press;
  btn_vec_t w_release;

  // Each line is fully independent; the slave board role disables them all.
  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_btn (
      .i_clk    (clk),
      .i_rst    (reset),
      .i_en     (isMaster),
      .i_pin    (ja_in[g]),
      .o_level  (w_level[g]),
      .o_press  (w_press[g]),
      .o_release(w_release[g])
    );
  end

  assign p2_level   = w_level;
  assign p2_press   = w_press;
  assign p2_release = w_release;

endmodule

// File: tb/tb_p2_button_link_rx.sv
// Directed bench for p2_button_link_rx with short debounce/repeat settings;
// expectations follow P2_AUTOREPEAT_EN when it is defined.
module tb_p2_button_link_rx;

`ifdef P2_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       isMaster;
  logic [4:0] ja_in;
  logic [4:0] p2_level;
  logic [4:0] p2_press;
  logic [4:0] p2_release;

  int total = 0;
  int bad   = 0;

  p2_button_link_rx #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .isMaster  (isMaster),
    .ja_in     (ja_in),
    .p2_level  (p2_level),
    .p2_press  (p2_press),
    .p2_release(p2_release)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] lvl,
                     input logic [4:0] prs, input logic [4:0] rel);
    total++;
    assert (p2_level === lvl) else begin
      bad++;
      $error("FAIL %s level: got %b expected %b", tag, p2_level, lvl);
    end
    total++;
    assert (p2_press === prs) else begin
      bad++;
      $error("FAIL %s press: got %b expected %b", tag, p2_press, prs);
    end
    total++;
    assert (p2_release === rel) else begin
      bad++;
      $error("FAIL %s release: got %b expected %b", tag, p2_release, rel);
    end
  endtask

  initial begin
    // Reset with every line held high.
    reset    = 1'b1;
    isMaster = 1'b1;
    ja_in    = 5'b11111;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("reset_hold", 5'b00000, 5'b00000, 5'b00000);
    end
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("all_rise", (i >= 6) ? 5'b11111 : 5'b00000,
          (i == 6) ? 5'b11111 : 5'b00000, 5'b00000);
    end
    ja_in = 5'b00000;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("all_fall", (i >= 6) ? 5'b00000 : 5'b11111, 5'b00000,
          (i == 6) ? 5'b11111 : 5'b00000);
    end

    // Glitch shorter than the debounce window.
    ja_in = 5'b00001;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("glitch_hi", 5'b00000, 5'b00000, 5'b00000);
    end
    ja_in = 5'b00000;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("glitch_lo", 5'b00000, 5'b00000, 5'b00000);
    end

    // Single line press and release.
    ja_in = 5'b00100;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("left_rise", (i >= 6) ? 5'b00100 : 5'b00000,
          (i == 6) ? 5'b00100 : 5'b00000, 5'b00000);
    end
    ja_in = 5'b00000;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("left_fall", (i >= 6) ? 5'b00000 : 5'b00100, 5'b00000,
          (i == 6) ? 5'b00100 : 5'b00000);
    end

    // Slave role: inactive, then enabling while a line is held.
    isMaster = 1'b0;
    ja_in    = 5'b00010;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("slave_idle", 5'b00000, 5'b00000, 5'b00000);
    end
    isMaster = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("master_up", (i >= 6) ? 5'b00010 : 5'b00000,
          (i == 6) ? 5'b00010 : 5'b00000, 5'b00000);
    end
    isMaster = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("master_drop", 5'b00000, 5'b00000, 5'b00000);
    end
    ja_in    = 5'b00000;
    isMaster = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("master_quiet", 5'b00000, 5'b00000, 5'b00000);
    end

    // Attack held 30 cycles: repeats only with the macro.
    ja_in = 5'b10000;
    for (int i = 1; i <= 40; i++) begin
      step();
      chk("attack_hold", (i >= 6 && i < 36) ? 5'b10000 : 5'b00000,
          ((i == 6) || (AR && i >= 14 && i < 36 && ((i - 14) % 3 == 0)))
            ? 5'b10000 : 5'b00000,
          (i == 36) ? 5'b10000 : 5'b00000);
      if (i == 30) ja_in = 5'b00000;
    end

    // Reset pulse while right is held and accepted.
    ja_in = 5'b01000;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("right_rise", (i >= 6) ? 5'b01000 : 5'b00000,
          (i == 6) ? 5'b01000 : 5'b00000, 5'b00000);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("right_rst", 5'b00000, 5'b00000, 5'b00000);
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("right_repress", (i >= 6) ? 5'b01000 : 5'b00000,
          (i == 6) ? 5'b01000 : 5'b00000, 5'b00000);
    end
    ja_in = 5'b00000;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("right_fall", (i >= 6) ? 5'b00000 : 5'b01000, 5'b00000,
          (i == 6) ? 5'b01000 : 5'b00000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
